// File: rtl/servo_pwm_gen.sv
// Three-channel servo PWM generator.
// A frame of PERIOD clk cycles is repeated while enabled; each channel drives
// its pin high for the first N cycles of a frame, where N is a per-channel
// shadow width captured only at frame start, so pulses never change mid-frame.
// Optional feature macro: SERVO_SLEW_EN limits each shadow update to SLEW_STEP.
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    asynchronous active-high reset
//   enable                   high runs frames, low idles after the current frame
//   x_value/y_value/fire_value  requested pulse widths in clk cycles
//   x_pwm/y_pwm/fire_pwm     registered servo drive pins
//   frame_tick               one-cycle pulse on the first cycle of every frame
//   busy                     high while a frame is running
module servo_pwm_gen #(
  parameter logic [19:0] PERIOD    = 20'd1000000,
  parameter logic [19:0] SLEW_STEP = 20'd500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [19:0] x_value,
  input  logic [19:0] y_value,
  input  logic [19:0] fire_value,
  output logic        x_pwm,
  output logic        y_pwm,
  output logic        fire_pwm,
  output logic        frame_tick,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [19:0] count, count_nxt;
  logic [19:0] x_sh, y_sh, f_sh;
  logic [19:0] x_sh_nxt, y_sh_nxt, f_sh_nxt;
  logic        load;

`ifdef SERVO_SLEW_EN
  // Move cur toward req by at most SLEW_STEP; differences taken only in the
  // non-negative direction so nothing under- or overflows.
  function automatic logic [19:0] slew(input logic [19:0] cur, input logic [19:0] req);
    logic [19:0] res;
    res = req;
    if (req > cur) begin
      if (20'(req - cur) > SLEW_STEP) res = 20'(cur + SLEW_STEP);
    end else begin
      if (20'(cur - req) > SLEW_STEP) res = 20'(cur - SLEW_STEP);
    end
    return res;
  endfunction
`endif

  // Next state, frame counter and shadow-load strobe.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          count_nxt = 20'd0;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (count == 20'(PERIOD - 20'd1)) begin
          count_nxt = 20'd0;
          if (enable) load = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          count_nxt = 20'(count + 20'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow widths only change on a frame-start load.
  always_comb begin
    x_sh_nxt = x_sh;
    y_sh_nxt = y_sh;
    f_sh_nxt = f_sh;
    if (load) begin
`ifdef SERVO_SLEW_EN
      x_sh_nxt = slew(x_sh, x_value);
      y_sh_nxt = slew(y_sh, y_value);
      f_sh_nxt = slew(f_sh, fire_value);
`else
      x_sh_nxt = x_value;
      y_sh_nxt = y_value;
      f_sh_nxt = fire_value;
`endif
    end
  end

  // Outputs are registered from the next-cycle state so they line up with
  // the counter; width >= PERIOD stays high because count never reaches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 20'd0;
      x_sh       <= 20'd0;
      y_sh       <= 20'd0;
      f_sh       <= 20'd0;
      x_pwm      <= 1'b0;
      y_pwm      <= 1'b0;
      fire_pwm   <= 1'b0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      x_sh       <= x_sh_nxt;
      y_sh       <= y_sh_nxt;
      f_sh       <= f_sh_nxt;
      x_pwm      <= (state_nxt == RUN) && (count_nxt < x_sh_nxt);
      y_pwm      <= (state_nxt == RUN) && (count_nxt < y_sh_nxt);
      fire_pwm   <= (state_nxt == RUN) && (count_nxt < f_sh_nxt);
      frame_tick <= (state_nxt == RUN) && (count_nxt == 20'd0);
      busy       <= (state_nxt == RUN);
    end
  end

endmodule
